// File: rtl/arb2_pkg.sv
// Shared constants for the two-client request buffer: default sizing,
// output source encoding and grant-counter width.
package arb2_pkg;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int GCNT_W    = 16;

    localparam logic SRC_C1 = 1'b0;
    localparam logic SRC_C2 = 1'b1;
endpackage

// File: rtl/arb2_fifo.sv
// Single-client synchronous FIFO. The head is read combinationally so the
// parent can pop it into its output register in the same cycle as the grant.
module arb2_fifo
    import arb2_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB separates full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/arb2_req_fifo.sv
// Two-client request buffer in front of a 2-way arbiter and a shared consumer.
// Optional per-client pop counters are enabled by ARB2_REQ_FIFO_GCNT_EN.
module arb2_req_fifo
    import arb2_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in1_valid,
    input  logic [DW-1:0]     in1_data,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic [DW-1:0]     in2_data,
    output logic              in2_ready,
    output logic              req1,
    output logic              req2,
    input  logic              gnt1,
    input  logic              gnt2,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic              out_src,
`ifdef ARB2_REQ_FIFO_GCNT_EN
    output logic [GCNT_W-1:0] gcnt1,
    output logic [GCNT_W-1:0] gcnt2,
`endif
    input  logic              out_ready
);
    logic          full1, full2, empty1, empty2;
    logic [DW-1:0] head1, head2;
    logic          push1, push2, pop1, pop2, stage_free;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_src_q, out_src_d;

    assign in1_ready = !full1 && !rst;
    assign in2_ready = !full2 && !rst;
    assign push1     = in1_valid && in1_ready;
    assign push2     = in2_valid && in2_ready;

    // Requests depend only on registered state and out_ready, never on gnt*.
    assign stage_free = !out_valid_q || out_ready;
    assign req1       = !empty1 && stage_free;
    assign req2       = !empty2 && stage_free;

    // Client 1 wins an illegal double grant.
    assign pop1 = gnt1 && req1;
    assign pop2 = gnt2 && req2 && !pop1;

    arb2_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .push_data(in1_data),
        .pop(pop1), .full(full1), .empty(empty1), .head(head1)
    );

    arb2_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst(rst), .push(push2), .push_data(in2_data),
        .pop(pop2), .full(full2), .empty(empty2), .head(head2)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (pop1) begin
            out_valid_d = 1'b1;
            out_data_d  = head1;
            out_src_d   = SRC_C1;
        end else if (pop2) begin
            out_valid_d = 1'b1;
            out_data_d  = head2;
            out_src_d   = SRC_C2;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_C1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB2_REQ_FIFO_GCNT_EN
    logic [GCNT_W-1:0] gcnt1_q, gcnt1_d, gcnt2_q, gcnt2_d;

    always_comb begin
        gcnt1_d = gcnt1_q;
        gcnt2_d = gcnt2_q;
        if (pop1 && gcnt1_q != {GCNT_W{1'b1}}) gcnt1_d = gcnt1_q + 1'b1;
        if (pop2 && gcnt2_q != {GCNT_W{1'b1}}) gcnt2_d = gcnt2_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt1_q <= '0;
            gcnt2_q <= '0;
        end else begin
            gcnt1_q <= gcnt1_d;
            gcnt2_q <= gcnt2_d;
        end
    end

    assign gcnt1 = gcnt1_q;
    assign gcnt2 = gcnt2_q;
`endif
endmodule

// File: tb/tb_arb2_req_fifo.sv
// Directed bench for arb2_req_fifo with a manual grant driver and a simple
// round-robin arbiter model; define ARB2_REQ_FIFO_GCNT_EN to cover counters.
module tb_arb2_req_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in1_valid = 1'b0, in2_valid = 1'b0;
    logic [7:0] in1_data = '0, in2_data = '0;
    logic       in1_ready, in2_ready;
    logic       req1, req2, gnt1, gnt2;
    logic       out_valid, out_src;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
`ifdef ARB2_REQ_FIFO_GCNT_EN
    logic [15:0] gcnt1, gcnt2;
`endif

    logic g1_man = 1'b0, g2_man = 1'b0, auto_arb = 1'b0, rr_c2 = 1'b0;
    logic a_gnt1, a_gnt2;
    int   n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // Round-robin arbiter model, used only when auto_arb is set.
    assign a_gnt1 = req1 && (!req2 || !rr_c2);
    assign a_gnt2 = req2 && !a_gnt1;
    assign gnt1   = auto_arb ? a_gnt1 : g1_man;
    assign gnt2   = auto_arb ? a_gnt2 : g2_man;

    always @(posedge clk) begin
        if (auto_arb && a_gnt1) rr_c2 <= 1'b1;
        else if (auto_arb && a_gnt2) rr_c2 <= 1'b0;
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            $display("xfer src=%0d data=%02h t=%0t", out_src, out_data, $time);
    end

    arb2_req_fifo #(.DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
        .req1(req1), .req2(req2), .gnt1(gnt1), .gnt2(gnt2),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
`ifdef ARB2_REQ_FIFO_GCNT_EN
        .gcnt1(gcnt1), .gcnt2(gcnt2),
`endif
        .out_ready(out_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic s);
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_data"}, out_data, d);
        check_val({tag, "_src"}, out_src, s);
    endtask

    initial begin
        // Reset state
        step(); step();
        check_val("rst_in1_ready", in1_ready, 0);
        check_val("rst_in2_ready", in2_ready, 0);
        check_val("rst_req1", req1, 0);
        check_val("rst_req2", req2, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_src", out_src, 0);
        rst = 1'b0;
        #1;
        check_val("rel_in1_ready", in1_ready, 1);
        check_val("rel_in2_ready", in2_ready, 1);

        // Single push and grant on client 1
        in1_valid = 1'b1; in1_data = 8'hA5;
        step();
        in1_valid = 1'b0;
        check_val("t1_req1", req1, 1);
        g1_man = 1'b1;
        step();
        g1_man = 1'b0;
        check_out("t1_out", 8'hA5, 0);
        check_val("t1_req1_empty", req1, 0);
        step();
        check_val("t1_consumed", out_valid, 0);

        // Fill client 2, overflow push dropped, drain in order
        for (int i = 0; i < 4; i++) begin
            in2_valid = 1'b1; in2_data = 8'h10 + 8'(i);
            step();
        end
        check_val("t2_full_ready", in2_ready, 0);
        in2_data = 8'h14;
        step();
        in2_valid = 1'b0;
        auto_arb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("t2_drain%0d", i), 8'h10 + 8'(i), 1);
        end
        step();
        check_val("t2_done_valid", out_valid, 0);
        check_val("t2_done_req2", req2, 0);
        auto_arb = 1'b0;

        // Both clients loaded, one pop per cycle, alternating
        in1_valid = 1'b1; in1_data = 8'h20; in2_valid = 1'b1; in2_data = 8'h30;
        step();
        in1_data = 8'h21; in2_data = 8'h31;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        auto_arb = 1'b1;
        step(); check_out("t3_a", 8'h20, 0);
        step(); check_out("t3_b", 8'h30, 1);
        step(); check_out("t3_c", 8'h21, 0);
        step(); check_out("t3_d", 8'h31, 1);
        step();
        check_val("t3_done_valid", out_valid, 0);
        auto_arb = 1'b0;

        // Downstream stall holds output and drops requests
        in1_valid = 1'b1; in1_data = 8'h40;
        step();
        in1_data = 8'h41;
        step();
        in1_valid = 1'b0;
        out_ready = 1'b0;
        g1_man = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("t4_hold%0d", i), 8'h40, 0);
            check_val($sformatf("t4_req1_low%0d", i), req1, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_val("t4_req1_resume", req1, 1);
        step();
        g1_man = 1'b0;
        check_out("t4_next", 8'h41, 0);
        step();
        check_val("t4_done_valid", out_valid, 0);

        // Double grant: client 1 wins; grant with empty FIFO ignored
        in1_valid = 1'b1; in1_data = 8'h50; in2_valid = 1'b1; in2_data = 8'h60;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        g1_man = 1'b1; g2_man = 1'b1;
        check_val("t5_req1", req1, 1);
        check_val("t5_req2", req2, 1);
        step();
        g1_man = 1'b0;
        check_out("t5_dbl", 8'h50, 0);
        step();
        check_out("t5_c2", 8'h60, 1);
        step();
        g2_man = 1'b0;
        check_val("t5_empty_valid", out_valid, 0);
        check_val("t5_empty_data", out_data, 8'h60);
        check_val("t5_empty_src", out_src, 1);

        // Fresh reset, then optional counter check
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`ifdef ARB2_REQ_FIFO_GCNT_EN
        check_val("t6_gcnt1_rst", gcnt1, 0);
        for (int i = 0; i < 5; i++) begin
            in1_valid = 1'b1; in1_data = 8'h70 + 8'(i);
            step();
            in1_valid = 1'b0; g1_man = 1'b1;
            step();
            g1_man = 1'b0;
            check_out($sformatf("t6_pop%0d", i), 8'h70 + 8'(i), 0);
        end
        check_val("t6_gcnt1", gcnt1, 5);
        check_val("t6_gcnt2", gcnt2, 0);
`endif

        // Reset mid-drain clears everything immediately
        for (int i = 0; i < 3; i++) begin
            in1_valid = 1'b1; in1_data = 8'h80 + 8'(i);
            step();
        end
        in1_valid = 1'b0;
        g1_man = 1'b1;
        step();
        check_out("t7_pre", 8'h80, 0);
        rst = 1'b1;
        #1;
        check_val("t7_rst_valid", out_valid, 0);
        check_val("t7_rst_data", out_data, 0);
        check_val("t7_rst_req1", req1, 0);
        check_val("t7_rst_ready", in1_ready, 0);
`ifdef ARB2_REQ_FIFO_GCNT_EN
        check_val("t7_rst_gcnt1", gcnt1, 0);
`endif
        step();
        rst = 1'b0;
        g1_man = 1'b0;
        #1;
        check_val("t7_rel_req1", req1, 0);
        check_val("t7_rel_ready", in1_ready, 1);
        step();
        check_val("t7_rel_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arb2_req_fifo.md
# arb2_req_fifo

Front-end request buffer for the two-client arbiter. It holds a per-client FIFO of payloads and drives `req1`/`req2` whenever a client has queued work. It consumes the arbiter's combinational `gnt1`/`gnt2` in the same cycle, popping the granted head into a single registered output stage with valid/ready handshake. It sits directly upstream of the arbiter and directly in front of the shared downstream consumer.

## Interface
- `DW`, default 8: payload width in bits.
- `DEPTH`, default 4: entries per client FIFO; power of two, ≥2.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset, asynchronous, active-high.
- `in1_valid` input 1: client 1 push request.
- `in1_data` input DW: client 1 payload.
- `in1_ready` output 1: client 1 FIFO can accept; push occurs when `in1_valid & in1_ready`.
- `in2_valid` input 1: client 2 push request.
- `in2_data` input DW: client 2 payload.
- `in2_ready` output 1: client 2 FIFO can accept.
- `req1` output 1: request to arbiter, client 1.
- `req2` output 1: request to arbiter, client 2.
- `gnt1` input 1: arbiter grant, client 1; combinational from `req*`.
- `gnt2` input 1: arbiter grant, client 2.
- `out_valid` output 1: output stage holds a granted payload.
- `out_data` output DW: granted payload.
- `out_src` output 1: 0 = from client 1, 1 = from client 2.
- `out_ready` input 1: downstream accepts; transfer occurs when `out_valid & out_ready`.

## Operation
- Each FIFO uses read/write pointers of width clog2(DEPTH)+1; the MSB distinguishes full from empty.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- `inN_ready` = !fullN, and is forced to 0 while `rst` is high.
- A push into a full FIFO is impossible; `in_ready` is low.
- `in_ready` does not consider a same-cycle pop, so a full FIFO refuses a push even in a pop cycle.
- Output stage free condition: `stage_free` = !out_valid | out_ready.
- Request generation:
  - `req1` = !empty1 & stage_free.
  - `req2` = !empty2 & stage_free.
  - Both are combinational from registered state and `out_ready` only, never from `gnt*`. This keeps the req→gnt→pop path loop-free.
- Pop rules:
  - FIFO N pops in the cycle `gntN & reqN` is true.
  - Its head loads into `out_data`, `out_src` ← N-1, and `out_valid` ← 1.
  - A grant without a matching request is ignored: no pop, no output change.
- Simultaneous `gnt1 & gnt2`:
  - This is illegal from the arbiter.
  - Client 1 wins; client 2 does not pop.
- Output stage update when no pop occurs:
  - `out_valid` ← 0 if `out_ready`; otherwise it holds.
  - `out_data` and `out_src` hold until consumed.
- Push and pop on the same FIFO in one cycle are both performed, and the occupancy is unchanged.

## Timing
- Reset values: pointers 0, `out_valid` 0, `out_data` 0, `out_src` 0.
  - Hence `req1` = `req2` = 0.
  - `in1_ready` = `in2_ready` = 0 during reset, and 1 after deassertion.
- Reset asserted mid-operation discards all queued entries and any held output immediately.
- Push-to-request latency: 1 cycle. Data pushed at edge k gives `reqN` = 1 in cycle k+1, when the stage is free.
- Grant-to-output latency: 1 cycle. With `gntN` in cycle k, `out_valid` = 1 with that payload in cycle k+1.
- Back-to-back throughput: with `out_ready` held high, one payload per cycle.
- When `out_ready` = 0 and `out_valid` = 1:
  - `req*` drop in the same cycle.
  - No grant or pop occurs.
  - The output holds its value.

## Configuration
- `ARB2_REQ_FIFO_GCNT_EN` defined:
  - Adds output `gcnt1` (16 bits) and output `gcnt2` (16 bits).
  - Each counts pops for its client.
  - Each saturates at 16'hFFFF and resets to 0.
- `ARB2_REQ_FIFO_GCNT_EN` undefined: the ports and the counter logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package `arb2_pkg`:
  - DW/DEPTH defaults.
  - Source encoding constants `SRC_C1` = 1'b0 and `SRC_C2` = 1'b1.
  - Counter width constant `GCNT_W` = 16.
- Sub-module `arb2_fifo`: single-client synchronous FIFO with push/pop/full/empty/head. It is instantiated twice.
- The top level holds request gating, pop select, the output register and the optional counters.

## Test plan
- Reset release, then one push `in1_data` = 8'hA5 → `req1` = 1 the next cycle. After the grant, `out_valid` = 1, `out_data` = A5, `out_src` = 0 one cycle later.
- Fill client 2 with 4 pushes (DEPTH = 4) and no grants → `in2_ready` = 0 after the 4th push. A 5th push is dropped, and the 4 entries drain in order.
- Both FIFOs loaded and `out_ready` high → exactly one pop per cycle, payloads match the granted client, and no entry is lost or duplicated.
- `out_ready` low while `out_valid` = 1 → `req1` = `req2` = 0, and `out_data` stable for 3 cycles. When `out_ready` rises, the transfer occurs and requests resume the same cycle.
- Force `gnt1` = `gnt2` = 1 with both requests → only client 1 pops and `out_src` = 0. Force `gnt2` = 1 with client 2 empty → no change.
- With `ARB2_REQ_FIFO_GCNT_EN`, perform 5 client-1 pops → `gcnt1` = 5 and `gcnt2` = 0. Assert `rst` mid-drain → counters, pointers and `out_valid` read 0 immediately.
